hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that produces the `stall`/`flush` controls for the IF/ID, ID/EX and EX/MEM pipeline buffers and the PC. It watches the instruction in decode, the instruction held in ID/EX, the branch outcome resolved in MEM, and the data-memory handshake. It holds load-use and memory-wait situations across cycles with a small FSM. It sits beside the buffers in the CPU top level and is the sole source of their `stall`/`flush` inputs.

## Interface

**Parameters**
- `LU_BUBBLES`, default 1. Number of bubble cycles inserted per load-use hazard. Legal range is 1–3; set it to 2 when MEM→EX forwarding is absent.

**Ports**
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `id_rs`, `id_rt`  in  4 each  source register indices of the instruction in decode (from IF/ID).
- `id_uses_rs`, `id_uses_rt`  in  1 each  the decode instruction actually reads that source.
- `ex_memread`  in  1  the instruction in ID/EX is a load.
- `ex_rd`  in  4  destination index of the ID/EX instruction.
- `mem_branch_taken`  in  1  branch in MEM resolved taken.
- `dmem_req`  in  1  the MEM stage has a data-memory access outstanding.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall`  out  1 each  hold the PC or buffer.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  load a bubble (all-zero) into the buffer.
- `state`  out  2  current FSM state, for debug.
- `stall_cycles`  out  16  saturating count of cycles with `pc_stall`=1.

## Operation

- **States:** `RUN`=0, `LOADUSE`=1, `MEMWAIT`=2. The encoding value 3 is illegal and is recovered to `RUN` on the next edge.
- **Hazard terms:**
  - `lu_hit` = `ex_memread` & `ex_rd`≠0 & ((`id_uses_rs` & `id_rs`==`ex_rd`) | (`id_uses_rt` & `id_rt`==`ex_rd`)).
  - `mw_hit` = `dmem_req` & !`dmem_ready`.
- **Priority:** `mw_hit` > `mem_branch_taken` > load-use.
- **Outputs:** combinational from the current state and inputs.
  - `mw_hit` in any state:
    - Assert `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` and `memwb_flush`; all other flushes are 0.
    - Next state is `MEMWAIT`. If the current state is not `MEMWAIT`, record it in `ret_state`.
    - The bubble counter is frozen.
  - Else if `mem_branch_taken`:
    - Assert `ifid_flush`, `idex_flush`, `exmem_flush`; all stalls are 0.
    - Next state is `RUN` and the bubble counter clears. A pending load-use is cancelled because the dependent instruction has been squashed.
  - Else if state is `RUN` and `lu_hit`:
    - Assert `pc_stall`, `ifid_stall`, `idex_flush`.
    - If `LU_BUBBLES`>1, go to `LOADUSE` with bubble counter = `LU_BUBBLES`-2; otherwise stay in `RUN`.
  - In state `LOADUSE` with no higher-priority event:
    - Assert the same three outputs as a `RUN`-state load-use.
    - If counter==0, go to `RUN`; else decrement the counter.
  - In state `MEMWAIT` with `mw_hit`=0:
    - All outputs are 0 and the next state is `ret_state`.
    - The stall is released in the cycle `dmem_ready` arrives.
- **Stall counter:** `stall_cycles` increments on every edge where `pc_stall`=1 and saturates at 16'hFFFF.

## Timing

- **Reset:** while `rst`=1, all stall and flush outputs are 0. On the edge:
  - `state` becomes `RUN`;
  - bubble counter and `ret_state` are cleared;
  - `stall_cycles` becomes 0.
- **Reset mid-operation:** reset aborts `LOADUSE`/`MEMWAIT` with no replay.
- **Latency:**
  - Hazard detection to control assertion is 0 cycles (same cycle).
  - A load-use hazard stalls for exactly `LU_BUBBLES` consecutive cycles.
- **Memory wait:** the stall lasts exactly as many cycles as `dmem_req`&!`dmem_ready` is high. Afterwards, the remaining load-use bubbles resume with the counter value unchanged.
- **Branch vs. memory wait:** when `mem_branch_taken` coincides with `mw_hit`, the branch is ignored that cycle. EX/MEM is frozen, so the branch is re-seen when the wait ends.
- **Counter saturation:** `stall_cycles` holds at FFFF and never wraps.

## Structure

- Shared package `hazard_pkg` contains:
  - the state enum `hz_state_t` with values `RUN`/`LOADUSE`/`MEMWAIT`;
  - `REG_IDX_W`=4;
  - `STALL_CNT_W`=16.
- One sub-module, `sat_counter` (width parameter; `clk`, `rst`, `inc`, `q`), implements `stall_cycles`. The FSM and bubble counter are inline.

## Test plan

1. **Load-use, single bubble:** `LU_BUBBLES`=1, `ex_memread`=1, `ex_rd`=5, `id_rs`=5, `id_uses_rs`=1 for one cycle → `pc_stall`/`ifid_stall`/`idex_flush`=1 for exactly 1 cycle; `stall_cycles`=1.
2. **Load-use, longer wait:** `LU_BUBBLES`=3 with the same hit → stall for 3 cycles with `state` sequence 0,1,1,0; and `ex_rd`=0 gives no stall.
3. **Memory wait:** `dmem_req`=1 with `dmem_ready` low for 4 cycles → four cycles of all four stalls plus `memwb_flush`, `state`=2. Outputs drop the cycle `dmem_ready`=1.
4. **Memory wait inside load-use:** `LU_BUBBLES`=3, `mw_hit` asserted in the 2nd bubble for 2 cycles → total `pc_stall` high for 5 cycles and the return to `LOADUSE` is verified.
5. **Branch cancels load-use:** `mem_branch_taken` during `LOADUSE` → `ifid_flush`/`idex_flush`/`exmem_flush`=1 with stalls 0, then `state`=`RUN`. Branch together with `mw_hit` → only stalls that cycle.
6. **Reset and saturation:** `rst` mid-`MEMWAIT` → next cycle `state`=0, outputs 0, counter 0. Forcing the counter to FFFF while stalling → it stays FFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package hazard_pkg;

   localparam int REG_IDX_W   = 4;
   localparam int STALL_CNT_W = 16;
   localparam int BUB_CNT_W   = 2;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LOADUSE = 2'd1,
      MEMWAIT = 2'd2
   } hz_state_t;

   // True when the decode instruction reads a source that matches the load target.
   function automatic logic src_match(input logic                 uses,
                                      input logic [REG_IDX_W-1:0] src,
                                      input logic [REG_IDX_W-1:0] rd);
      return uses && (src == rd);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter
   import hazard_pkg::*;
#(
   parameter int W = STALL_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (inc && (q_q != {W{1'b1}})) begin
         q_d = q_q + ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generator for the PC and the IF/ID, ID/EX, EX/MEM, MEM/WB buffers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   RUN     | normal flow; a load-use hit inserts the first bubble here
//   LOADUSE | inserting the remaining load-use bubbles (bub_cnt_q left-1)
//   MEMWAIT | data memory busy; everything frozen, resumes ret_state_q
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int LU_BUBBLES = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_IDX_W-1:0]   id_rs,
   input  logic [REG_IDX_W-1:0]   id_rt,
   input  logic                   id_uses_rs,
   input  logic                   id_uses_rt,
   input  logic                   ex_memread,
   input  logic [REG_IDX_W-1:0]   ex_rd,
   input  logic                   mem_branch_taken,
   input  logic                   dmem_req,
   input  logic                   dmem_ready,
   output logic                   pc_stall,
   output logic                   ifid_stall,
   output logic                   idex_stall,
   output logic                   exmem_stall,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic                   exmem_flush,
   output logic                   memwb_flush,
   output logic [1:0]             state,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int                 LU_INIT_I = (LU_BUBBLES > 1) ? (LU_BUBBLES - 2) : 0;
   localparam logic [BUB_CNT_W-1:0] LU_INIT = LU_INIT_I[BUB_CNT_W-1:0];
   localparam logic [BUB_CNT_W-1:0] BUB_ONE = {{(BUB_CNT_W-1){1'b0}}, 1'b1};

   hz_state_t             state_q, state_d;
   hz_state_t             ret_state_q, ret_state_d;
   logic [BUB_CNT_W-1:0]  bub_cnt_q, bub_cnt_d;

   logic lu_hit;
   logic mw_hit;

   assign lu_hit = ex_memread && (ex_rd != '0) &&
                   (src_match(id_uses_rs, id_rs, ex_rd) ||
                    src_match(id_uses_rt, id_rt, ex_rd));
   assign mw_hit = dmem_req && !dmem_ready;

   always_comb begin
      state_d     = state_q;
      ret_state_d = ret_state_q;
      bub_cnt_d   = bub_cnt_q;
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      idex_stall  = 1'b0;
      exmem_stall = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;

      if (mw_hit) begin
         pc_stall    = 1'b1;
         ifid_stall  = 1'b1;
         idex_stall  = 1'b1;
         exmem_stall = 1'b1;
         memwb_flush = 1'b1;
         state_d     = MEMWAIT;
         if (state_q != MEMWAIT) begin
            ret_state_d = (state_q == LOADUSE) ? LOADUSE : RUN;
         end
      end else if (mem_branch_taken) begin
         // Squashing the dependent instruction makes any pending bubbles moot.
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         state_d     = RUN;
         bub_cnt_d   = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (lu_hit) begin
                  pc_stall   = 1'b1;
                  ifid_stall = 1'b1;
                  idex_flush = 1'b1;
                  if (LU_BUBBLES > 1) begin
                     state_d   = LOADUSE;
                     bub_cnt_d = LU_INIT;
                  end
               end
            end
            LOADUSE: begin
               pc_stall   = 1'b1;
               ifid_stall = 1'b1;
               idex_flush = 1'b1;
               if (bub_cnt_q == '0) begin
                  state_d = RUN;
               end else begin
                  bub_cnt_d = bub_cnt_q - BUB_ONE;
               end
            end
            MEMWAIT: begin
               state_d = ret_state_q;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end

      if (rst) begin
         pc_stall    = 1'b0;
         ifid_stall  = 1'b0;
         idex_stall  = 1'b0;
         exmem_stall = 1'b0;
         ifid_flush  = 1'b0;
         idex_flush  = 1'b0;
         exmem_flush = 1'b0;
         memwb_flush = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         ret_state_q <= RUN;
         bub_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ret_state_q <= ret_state_d;
         bub_cnt_q   <= bub_cnt_d;
      end
   end

   assign state = state_q;

   sat_counter #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (pc_stall),
      .q   (stall_cycles)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl with LU_BUBBLES = 1, 2 and 3 side by side.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_rs, id_rt, ex_rd;
   logic       id_uses_rs, id_uses_rt, ex_memread;
   logic       mem_branch_taken, dmem_req, dmem_ready;

   logic        pc_s   [3];
   logic        ifid_s [3];
   logic        idex_s [3];
   logic        exmem_s[3];
   logic        ifidf_s[3];
   logic        idexf_s[3];
   logic        exmemf_s[3];
   logic        memwbf_s[3];
   logic [1:0]  st_s   [3];
   logic [15:0] sc_s   [3];

   int total = 0;
   int bad   = 0;

   // Reference model: bubbles still owed, memory-wait flag, stall count.
   int rem_m [3];
   bit wt_m  [3];
   int cnt_m [3];

   always #5 clk = ~clk;

   hazard_ctrl #(.LU_BUBBLES(1)) u_lu1 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_branch_taken(mem_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_s[0]), .ifid_stall(ifid_s[0]), .idex_stall(idex_s[0]), .exmem_stall(exmem_s[0]),
      .ifid_flush(ifidf_s[0]), .idex_flush(idexf_s[0]), .exmem_flush(exmemf_s[0]),
      .memwb_flush(memwbf_s[0]), .state(st_s[0]), .stall_cycles(sc_s[0]));

   hazard_ctrl #(.LU_BUBBLES(2)) u_lu2 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_branch_taken(mem_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_s[1]), .ifid_stall(ifid_s[1]), .idex_stall(idex_s[1]), .exmem_stall(exmem_s[1]),
      .ifid_flush(ifidf_s[1]), .idex_flush(idexf_s[1]), .exmem_flush(exmemf_s[1]),
      .memwb_flush(memwbf_s[1]), .state(st_s[1]), .stall_cycles(sc_s[1]));

   hazard_ctrl #(.LU_BUBBLES(3)) u_lu3 (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .ex_memread(ex_memread), .ex_rd(ex_rd),
      .mem_branch_taken(mem_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .pc_stall(pc_s[2]), .ifid_stall(ifid_s[2]), .idex_stall(idex_s[2]), .exmem_stall(exmem_s[2]),
      .ifid_flush(ifidf_s[2]), .idex_flush(idexf_s[2]), .exmem_flush(exmemf_s[2]),
      .memwb_flush(memwbf_s[2]), .state(st_s[2]), .stall_cycles(sc_s[2]));

   // Control bits: {pc, ifid, idex, exmem stalls, ifid, idex, exmem, memwb flushes}
   localparam logic [7:0] C_NONE = 8'b0000_0000;
   localparam logic [7:0] C_LU   = 8'b1100_0100;
   localparam logic [7:0] C_MW   = 8'b1111_0001;
   localparam logic [7:0] C_BR   = 8'b0000_1110;

   typedef struct {
      logic [3:0] rs, rt, rd;
      logic       urs, urt, memrd, br, req, rdy;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [7:0] ctl_of(input int g);
      return {pc_s[g], ifid_s[g], idex_s[g], exmem_s[g],
              ifidf_s[g], idexf_s[g], exmemf_s[g], memwbf_s[g]};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_idle();
      id_rs = 0; id_rt = 0; ex_rd = 0;
      id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0;
      mem_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
   endtask

   task automatic set_lu();
      set_idle();
      ex_memread = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
   endtask

   task automatic do_reset();
      set_idle();
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      for (int g = 0; g < 3; g++) begin
         rem_m[g] = 0; wt_m[g] = 0; cnt_m[g] = 0;
      end
   endtask

   task automatic hcheck(input string nm, input int g, input logic [7:0] ectl, input logic [1:0] est);
      @(negedge clk);
      chk({nm, "_ctl"}, int'(ctl_of(g)), int'(ectl));
      chk({nm, "_state"}, int'(st_s[g]), int'(est));
      @(posedge clk); #1;
   endtask

   // One model-checked cycle for all three instances using the current inputs.
   task automatic mcycle();
      bit lu, mw;
      logic [7:0] ectl;
      int est;
      @(negedge clk);
      lu = ex_memread && (ex_rd != 0) &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
      mw = dmem_req && !dmem_ready;
      for (int g = 0; g < 3; g++) begin
         est = wt_m[g] ? 2 : (rem_m[g] > 0 ? 1 : 0);
         ectl = C_NONE;
         if (rst) begin
            ectl = C_NONE;
         end else if (mw) begin
            ectl = C_MW; wt_m[g] = 1;
         end else if (mem_branch_taken) begin
            ectl = C_BR; rem_m[g] = 0; wt_m[g] = 0;
         end else if (wt_m[g]) begin
            wt_m[g] = 0;
         end else if (rem_m[g] > 0) begin
            ectl = C_LU; rem_m[g]--;
         end else if (lu) begin
            ectl = C_LU; rem_m[g] = g;
         end
         chk($sformatf("rnd_ctl%0d", g), int'(ctl_of(g)), int'(ectl));
         chk($sformatf("rnd_state%0d", g), int'(st_s[g]), est);
         chk($sformatf("rnd_cnt%0d", g), int'(sc_s[g]), cnt_m[g]);
         if (rst) begin
            rem_m[g] = 0; wt_m[g] = 0; cnt_m[g] = 0;
         end else if (ectl[7] && cnt_m[g] < 65535) begin
            cnt_m[g]++;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1;
      set_idle();
      @(posedge clk); #1;
      do_reset();

      // Reset state
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("reset_ctl%0d", g), int'(ctl_of(g)), 0);
         chk($sformatf("reset_state%0d", g), int'(st_s[g]), 0);
         chk($sformatf("reset_cnt%0d", g), int'(sc_s[g]), 0);
      end
      @(posedge clk); #1;

      //              rs rt rd urs urt memrd br req rdy exp
      vecs.push_back('{4'd5, 4'd0, 4'd5, 1, 0, 1, 0, 0, 0, C_LU});
      vecs.push_back('{4'd0, 4'd5, 4'd5, 0, 1, 1, 0, 0, 0, C_LU});
      vecs.push_back('{4'd0, 4'd0, 4'd0, 1, 1, 1, 0, 0, 0, C_NONE});
      vecs.push_back('{4'd5, 4'd0, 4'd5, 1, 0, 0, 0, 0, 0, C_NONE});
      vecs.push_back('{4'd5, 4'd0, 4'd5, 0, 0, 1, 0, 0, 0, C_NONE});
      vecs.push_back('{4'd4, 4'd3, 4'd5, 1, 1, 1, 0, 0, 0, C_NONE});
      vecs.push_back('{4'd4, 4'd5, 4'd5, 1, 0, 1, 0, 0, 0, C_NONE});
      vecs.push_back('{4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 0, C_MW});
      vecs.push_back('{4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 1, 1, C_NONE});
      vecs.push_back('{4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 0, 0, C_BR});
      vecs.push_back('{4'd0, 4'd0, 4'd0, 0, 0, 0, 1, 1, 0, C_MW});
      vecs.push_back('{4'd5, 4'd0, 4'd5, 1, 0, 1, 1, 0, 0, C_BR});
      vecs.push_back('{4'd5, 4'd0, 4'd5, 1, 0, 1, 0, 1, 0, C_MW});
      vecs.push_back('{4'd15, 4'd15, 4'd15, 1, 1, 1, 0, 1, 1, C_LU});

      for (int i = 0; i < vecs.size(); i++) begin
         id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_rd = vecs[i].rd;
         id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt; ex_memread = vecs[i].memrd;
         mem_branch_taken = vecs[i].br; dmem_req = vecs[i].req; dmem_ready = vecs[i].rdy;
         hcheck($sformatf("vec%0d", i), 0, vecs[i].exp, 2'd0);
         set_idle();
         @(posedge clk); #1;
      end

      // Single bubble: exactly one stall cycle, count 1
      do_reset();
      set_lu();
      hcheck("lu1_a", 0, C_LU, 2'd0);
      set_idle();
      hcheck("lu1_b", 0, C_NONE, 2'd0);
      chk("lu1_cnt", int'(sc_s[0]), 1);

      // Three bubbles with a 2-cycle memory wait inside the second one
      do_reset();
      set_lu();
      hcheck("lumw_0", 2, C_LU, 2'd0);
      set_idle(); dmem_req = 1;
      hcheck("lumw_1", 2, C_MW, 2'd1);
      hcheck("lumw_2", 2, C_MW, 2'd2);
      dmem_ready = 1;
      hcheck("lumw_3", 2, C_NONE, 2'd2);
      set_idle();
      hcheck("lumw_4", 2, C_LU, 2'd1);
      hcheck("lumw_5", 2, C_LU, 2'd1);
      hcheck("lumw_6", 2, C_NONE, 2'd0);
      chk("lumw_cnt", int'(sc_s[2]), 5);

      // Branch cancels load-use; branch deferred while memory waits
      do_reset();
      set_lu();
      hcheck("br_0", 2, C_LU, 2'd0);
      set_idle(); mem_branch_taken = 1;
      hcheck("br_1", 2, C_BR, 2'd1);
      set_idle();
      hcheck("br_2", 2, C_NONE, 2'd0);
      set_lu();
      hcheck("brmw_0", 2, C_LU, 2'd0);
      set_idle(); mem_branch_taken = 1; dmem_req = 1;
      hcheck("brmw_1", 2, C_MW, 2'd1);
      dmem_req = 0;
      hcheck("brmw_2", 2, C_BR, 2'd2);
      set_idle();
      hcheck("brmw_3", 2, C_NONE, 2'd0);

      // Reset in the middle of a memory wait
      do_reset();
      dmem_req = 1;
      hcheck("rstmw_0", 0, C_MW, 2'd0);
      hcheck("rstmw_1", 0, C_MW, 2'd2);
      rst = 1;
      hcheck("rstmw_2", 0, C_NONE, 2'd2);
      rst = 0; set_idle();
      hcheck("rstmw_3", 0, C_NONE, 2'd0);
      chk("rstmw_cnt", int'(sc_s[0]), 0);

      // Saturation
      force u_lu1.u_stall_cnt.q_q = 16'hFFFE;
      #1;
      release u_lu1.u_stall_cnt.q_q;
      dmem_req = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("sat_%0d", k), int'(sc_s[0]), (k == 0) ? 32'hFFFE : 32'hFFFF);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("sat_hold", int'(sc_s[0]), 32'hFFFF);
      @(posedge clk); #1;

      // Randomized traffic against the reference model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         id_rs            = 4'($urandom_range(0, 3));
         id_rt            = 4'($urandom_range(0, 3));
         ex_rd            = 4'($urandom_range(0, 3));
         id_uses_rs       = 1'($urandom_range(0, 1));
         id_uses_rt       = 1'($urandom_range(0, 1));
         ex_memread       = 1'($urandom_range(0, 1));
         mem_branch_taken = ($urandom_range(0, 7) == 0);
         dmem_req         = ($urandom_range(0, 2) == 0);
         dmem_ready       = 1'($urandom_range(0, 1));
         rst              = ($urandom_range(0, 199) == 0);
         mcycle();
      end
      rst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
